// File: rtl/mem_dump_uart.sv
// Reads a contiguous external-memory range and streams it out on UART TX (8N1).
// Optional trailer frame with the 8-bit byte sum: define MEM_DUMP_UART_CHECKSUM_EN.
module mem_dump_uart #(
    parameter int unsigned CLK_DIV   = 104,
    parameter int unsigned READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] base_adr,
    input  logic [20:0] length,
    output logic [20:0] adr,
    output logic        read,
    input  logic [7:0]  data_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, READ, SEND, NEXT, FINISH} state_t;

    localparam int unsigned CMAX = (CLK_DIV > READ_WAIT) ? CLK_DIV : READ_WAIT;
    localparam int unsigned CW   = $clog2(CMAX);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_READ_END = CW'(READ_WAIT - 1);

    state_t      state_q, state_d;
    logic [20:0] adr_q, adr_d, count_q, count_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        busy_q, busy_d;
`ifdef MEM_DUMP_UART_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
    logic        trailer_q, trailer_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            count_q   <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
`ifdef MEM_DUMP_UART_CHECKSUM_EN
            sum_q     <= '0;
            trailer_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
`ifdef MEM_DUMP_UART_CHECKSUM_EN
            sum_q     <= sum_d;
            trailer_q <= trailer_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        count_d   = count_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
`ifdef MEM_DUMP_UART_CHECKSUM_EN
        sum_d     = sum_q;
        trailer_d = trailer_q;
`endif
        read = 1'b0;
        tx   = 1'b1;
        done = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    adr_d   = base_adr;
                    count_d = length;
                    cnt_d   = '0;
                    bit_d   = '0;
`ifdef MEM_DUMP_UART_CHECKSUM_EN
                    sum_d     = '0;
                    trailer_d = 1'b0;
`endif
                    if (length != '0) begin
                        busy_d  = 1'b1;
                        state_d = READ;
                    end else begin
`ifdef MEM_DUMP_UART_CHECKSUM_EN
                        shift_d   = '0;
                        trailer_d = 1'b1;
                        state_d   = SEND;
`else
                        state_d   = FINISH;
`endif
                    end
                end
            end
            READ: begin
                read = 1'b1;
                if (cnt_q == CNT_READ_END) begin
                    shift_d = data_in;
`ifdef MEM_DUMP_UART_CHECKSUM_EN
                    sum_d   = sum_q + data_in;
`endif
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SEND;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEND: begin
                // Data bits leave from shift_q[0]; the register shifts at each data-bit boundary.
                if (bit_q == 4'd0)      tx = 1'b0;
                else if (bit_q == 4'd9) tx = 1'b1;
                else                    tx = shift_q[0];
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (bit_q != 4'd0 && bit_q != 4'd9) shift_d = shift_q >> 1;
                    if (bit_q == 4'd9) begin
                        bit_d = '0;
`ifdef MEM_DUMP_UART_CHECKSUM_EN
                        state_d = trailer_q ? FINISH : NEXT;
`else
                        state_d = NEXT;
`endif
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NEXT: begin
                adr_d   = adr_q + 21'd1;
                count_d = count_q - 21'd1;
                cnt_d   = '0;
                bit_d   = '0;
                if (count_q == 21'd1) begin
`ifdef MEM_DUMP_UART_CHECKSUM_EN
                    shift_d   = sum_q;
                    trailer_d = 1'b1;
                    state_d   = SEND;
`else
                    state_d   = FINISH;
`endif
                end else begin
                    state_d = READ;
                end
            end
            FINISH: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign adr  = adr_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mem_dump_uart.sv
// Self-checking bench for mem_dump_uart: directed and random dumps checked
// against a byte/address/timing model derived from the frame and period rules.
module tb_mem_dump_uart;

    localparam int unsigned CD = 4;
    localparam int unsigned RW = 2;
    localparam int unsigned PERIOD = RW + 10 * CD + 1;
`ifdef MEM_DUMP_UART_CHECKSUM_EN
    localparam int unsigned CSUM = 1;
`else
    localparam int unsigned CSUM = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [20:0] base_adr, length, adr;
    logic        read, tx, busy, done;
    logic [7:0]  data_in;
    logic [7:0]  mem [256];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_dump_uart #(.CLK_DIV(CD), .READ_WAIT(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_adr(base_adr),
        .length(length), .adr(adr), .read(read), .data_in(data_in),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign data_in = mem[adr[7:0]];

    // Observation logs
    logic [7:0]  rx_q[$];
    int          frame_err = 0;
    logic [20:0] rd_adr_q[$];
    int          rd_len_q[$];
    int          rd_cyc_q[$];
    int          done_q[$];
    bit          rd_prev = 0, adr_moved = 0, busy_seen = 0, tx_low_seen = 0;
    logic [20:0] run_adr;
    int          run_len, run_start;

    always @(negedge clk) begin
        if (read === 1'b1) begin
            if (!rd_prev) begin
                run_adr = adr; run_len = 0; run_start = cyc;
            end
            if (adr !== run_adr) adr_moved = 1;
            run_len++;
        end else if (rd_prev) begin
            rd_adr_q.push_back(run_adr);
            rd_len_q.push_back(run_len);
            rd_cyc_q.push_back(run_start);
        end
        rd_prev = (read === 1'b1);
        if (busy === 1'b1) busy_seen = 1;
        if (tx !== 1'b1) tx_low_seen = 1;
        if (done === 1'b1) done_q.push_back(cyc);
    end

    // UART receiver sampling mid-bit
    always begin
        @(negedge clk);
        if (reset === 1'b0 && tx === 1'b0) begin
            logic [7:0] b;
            repeat (CD / 2) @(negedge clk);
            if (tx !== 1'b0) frame_err++;
            for (int k = 0; k < 8; k++) begin
                repeat (CD) @(negedge clk);
                b[k] = tx;
            end
            repeat (CD) @(negedge clk);
            if (tx !== 1'b1) frame_err++;
            rx_q.push_back(b);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rx_q.delete(); rd_adr_q.delete(); rd_len_q.delete(); rd_cyc_q.delete(); done_q.delete();
        frame_err = 0; adr_moved = 0; busy_seen = 0; tx_low_seen = 0;
    endtask

    task automatic do_dump(input string tag, input logic [20:0] b, input logic [20:0] n, input bit inject);
        logic [7:0]  exp_bytes[$];
        logic [20:0] exp_adr[$];
        logic [20:0] a;
        logic [7:0]  sum;
        int t0, exp_done, limit;
        sum = 8'h00;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 21'(i);
            exp_adr.push_back(a);
            exp_bytes.push_back(mem[a[7:0]]);
            sum = sum + mem[a[7:0]];
        end
        if (CSUM != 0) exp_bytes.push_back(sum);
        clear_logs();
        @(negedge clk);
        start = 1'b1; base_adr = b; length = n; t0 = cyc;
        exp_done = t0 + 1 + int'(n) * int'(PERIOD) + int'(CSUM * 10 * CD);
        @(negedge clk);
        start = 1'b0; base_adr = $urandom; length = $urandom;
        chk({tag, " busy_after_start"}, {31'd0, busy}, (n != 0) ? 32'd1 : 32'd0);
        if (inject) begin
            repeat (60) @(negedge clk);
            start = 1'b1; base_adr = 21'h00050; length = 21'd7;
            @(negedge clk);
            start = 1'b0;
        end
        limit = exp_done + 200;
        while (done_q.size() == 0 && cyc < limit) @(negedge clk);
        repeat (5) @(negedge clk);
        chk({tag, " done_count"}, done_q.size(), 32'd1);
        chk({tag, " done_cycle"}, (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        chk({tag, " busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, " rx_count"}, rx_q.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hxxxxxxxx, {24'd0, exp_bytes[i]});
        chk({tag, " frame_err"}, frame_err, 32'd0);
        chk({tag, " read_count"}, rd_adr_q.size(), exp_adr.size());
        for (int i = 0; i < exp_adr.size(); i++) begin
            chk($sformatf("%s adr%0d", tag, i), (i < rd_adr_q.size()) ? {11'd0, rd_adr_q[i]} : 32'hxxxxxxxx, {11'd0, exp_adr[i]});
            chk($sformatf("%s rdlen%0d", tag, i), (i < rd_len_q.size()) ? rd_len_q[i] : -1, RW);
        end
        if (n != 0)
            chk({tag, " first_read_cycle"}, (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1, t0 + 1);
        chk({tag, " adr_stable"}, {31'd0, adr_moved}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_adr = '0; length = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("reset tx", {31'd0, tx}, 32'd1);
        chk("reset read", {31'd0, read}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset adr", {11'd0, adr}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a frame
        clear_logs();
        start = 1'b1; base_adr = 21'h00040; length = 21'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset tx", {31'd0, tx}, 32'd1);
        chk("midreset read", {31'd0, read}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset adr", {11'd0, adr}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_logs();
        repeat (100) @(negedge clk);
        chk("postreset tx_quiet", {31'd0, tx_low_seen}, 32'd0);
        chk("postreset reads", rd_adr_q.size(), 32'd0);
        chk("postreset done", done_q.size(), 32'd0);
        chk("postreset busy", {31'd0, busy_seen}, 32'd0);

        // Basic dump
        mem[8'h00] = 8'hA5; mem[8'h01] = 8'h3C; mem[8'h02] = 8'hFF;
        do_dump("basic", 21'h00100, 21'd3, 1'b0);

        // Zero length
        do_dump("zero", 21'h01234, 21'd0, 1'b0);
        chk("zero busy_never", {31'd0, busy_seen}, 32'd0);
        chk("zero tx_activity", {31'd0, tx_low_seen}, CSUM);

        // Address wrap
        do_dump("wrap", 21'h1FFFFF, 21'd2, 1'b0);

        // Start while busy is ignored
        do_dump("ignore", 21'h00200, 21'd3, 1'b1);

        // Random dumps
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            do_dump($sformatf("rand%0d", r), 21'($urandom), 21'($urandom_range(1, 4)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
